// File: rtl/gcd_pkg.sv
// Shared types and constants for the subtract-and-compare GCD controller and datapath.
package gcd_pkg;

    localparam int DATA_W = 16;

    localparam logic SEL_A   = 1'b0;
    localparam logic SEL_B   = 1'b1;
    localparam logic BUS_EXT = 1'b1;
    localparam logic BUS_SUB = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_A,
        LOAD_B,
        COMPARE,
        SUB_A,
        SUB_B,
        DONE,
        ERR
    } state_e;

endpackage

// File: rtl/gcd_iter_counter.sv
// Saturating subtract-step counter; limit_o flags that MAX_ITER steps have been taken.
module gcd_iter_counter #(
    parameter int MAX_ITER = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic limit_o
);
    localparam int CW = $clog2(MAX_ITER + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MAX_ITER);

    logic [CW-1:0] cnt_q;

    assign limit_o = (cnt_q == LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (clr_i)
            cnt_q <= '0;
        else if (inc_i && !limit_o)
            cnt_q <= cnt_q + CW'(1);
    end

endmodule

// File: rtl/gcd_controller.sv
// Control FSM for the GCD datapath: loads operands, steps subtractions until equal,
// and aborts with err once the iteration limit is reached.
module gcd_controller
    import gcd_pkg::*;
#(
    parameter int MAX_ITER = 65535
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic lt,
    input  logic gt,
    input  logic eq,
    output logic LdA,
    output logic LdB,
    output logic sel1,
    output logic sel2,
    output logic sel_in,
    output logic busy,
    output logic done,
    output logic err
);
    state_e state_q, state_d;
    logic   limit;

    gcd_iter_counter #(.MAX_ITER(MAX_ITER)) u_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (state_q == LOAD_B),
        .inc_i  ((state_q == SUB_A) || (state_q == SUB_B)),
        .limit_o(limit)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = LOAD_A;
            LOAD_A:  state_d = LOAD_B;
            LOAD_B:  state_d = COMPARE;
            // A flag-less compare is an illegal datapath state; finish rather than spin.
            COMPARE: begin
                if (eq)         state_d = DONE;
                else if (limit) state_d = ERR;
                else if (lt)    state_d = SUB_B;
                else if (gt)    state_d = SUB_A;
                else            state_d = DONE;
            end
            SUB_A:   state_d = COMPARE;
            SUB_B:   state_d = COMPARE;
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next state, so they are a pure function of state_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            LdA     <= 1'b0;
            LdB     <= 1'b0;
            sel1    <= SEL_A;
            sel2    <= SEL_A;
            sel_in  <= BUS_SUB;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            LdA     <= (state_d == LOAD_A) || (state_d == SUB_A);
            LdB     <= (state_d == LOAD_B) || (state_d == SUB_B);
            sel1    <= (state_d == SUB_B) ? SEL_B : SEL_A;
            sel2    <= (state_d == SUB_A) ? SEL_B : SEL_A;
            sel_in  <= ((state_d == LOAD_A) || (state_d == LOAD_B)) ? BUS_EXT : BUS_SUB;
            busy    <= (state_d == LOAD_A) || (state_d == LOAD_B) || (state_d == COMPARE) ||
                       (state_d == SUB_A)  || (state_d == SUB_B);
            done    <= (state_d == DONE);
            err     <= (state_d == ERR) || (err && (state_d == IDLE));
        end
    end

endmodule

// File: doc/gcd_controller.md
# gcd_controller

- Control FSM for the 16-bit subtract-and-compare GCD datapath; sits directly beside it and drives its load and mux-select inputs.
- Consumes the datapath's `lt`/`gt`/`eq` comparison flags.
- Sequences operand loading, repeated subtraction and termination.
- Reports `busy`/`done`/`err` to the host, with an iteration limit that catches non-terminating operand pairs (either operand zero).

## Interface
- `MAX_ITER`, default 65535: maximum number of subtract steps before aborting with `err`.
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request a new GCD; sampled only in IDLE.
- `lt`, `gt`, `eq`  in  1 each  datapath flags for A<B, A>B, A==B, from registered A/B.
- `LdA`, `LdB`  out  1 each  load enables for the datapath A/B registers.
- `sel1`, `sel2`  out  1 each  subtractor operand selects; 0 selects A, 1 selects B.
- `sel_in`  out  1  bus source; 1 selects external `data_in`, 0 selects subtractor output.
- `busy`  out  1  high in every state except IDLE, DONE and ERR.
- `done`  out  1  one-cycle pulse; the result is valid in register A on that cycle.
- `err`  out  1  iteration limit hit; held until the next accepted `start`.

## Operation
States and transitions:
- IDLE: all outputs 0 except a held `err`. `start`=1 goes to LOAD_A and clears `err`.
- LOAD_A: `LdA`=1, `sel_in`=1. Host must drive operand A on `data_in` this cycle. Goes to LOAD_B.
- LOAD_B: `LdB`=1, `sel_in`=1. Host drives operand B. Iteration count is cleared to 0. Goes to COMPARE.
- COMPARE: no loads. Priority is `eq` > count==`MAX_ITER` > `lt` > `gt`.
  - `eq` goes to DONE.
  - Limit reached goes to ERR.
  - `lt` goes to SUB_B.
  - `gt` goes to SUB_A.
  - No flag set (illegal) is treated as `eq`.
- SUB_A: `sel1`=0, `sel2`=1, `sel_in`=0, `LdA`=1, so A←A−B. Count +1. Goes to COMPARE.
- SUB_B: `sel1`=1, `sel2`=0, `sel_in`=0, `LdB`=1, so B←B−A. Count +1. Goes to COMPARE.
- DONE: `done`=1 for exactly one cycle. Goes to IDLE.
- ERR: `err` is set. Goes to IDLE; `err` stays high there.

Rules:
- All datapath-control outputs are Moore (a function of state only). No output depends combinationally on `start`.
- Iteration counter is `$clog2(MAX_ITER+1)` bits and saturates at `MAX_ITER`; it never wraps.
- `start` outside IDLE is ignored. No queuing.
- A zero operand never converges; it must end in ERR after exactly `MAX_ITER` subtract steps.

## Timing
- Reset (asynchronous assert, synchronous release): state IDLE, count 0.
- Every output is 0 during and after reset, including `err`.
- Reset asserted mid-operation aborts immediately. No `done` or `err` is produced for the aborted run.
- `start` accepted in cycle t: LOAD_A at t+1, LOAD_B at t+2, first COMPARE at t+3.
- Each subtract step costs 2 cycles (SUB then COMPARE).
- `done` occurs at cycle t+4+2N for N subtract steps.
- `err` first shows high at cycle t+4+2·`MAX_ITER`.
- Back-to-back: `start` may be accepted in the IDLE cycle directly after DONE.

## Structure
- Shared package `gcd_pkg` holds:
  - state enum (IDLE, LOAD_A, LOAD_B, COMPARE, SUB_A, SUB_B, DONE, ERR);
  - select constants SEL_A=0, SEL_B=1, BUS_EXT=1, BUS_SUB=0;
  - data width constant 16.
- One sub-module is natural: `gcd_iter_counter`, a saturating counter with clear, increment and a limit-reached flag.
- The FSM lives in `gcd_controller`.
- A top-level wrapper pairing the controller with the datapath is used by the bench.

## Test plan
- A=48, B=18, `start` at cycle 0 → subtracts A,A,B,A (N=4); `done` at cycle 12; A=6; `busy` high cycles 1–11.
- A=7, B=7 → N=0; `done` at cycle 4; A=7; `LdA`/`LdB` never asserted with `sel_in`=0.
- `MAX_ITER`=8, A=0, B=5 → eight SUB_B steps; `err` high from cycle 20 until the next `start`; `done` never pulses.
- A=48, B=18 with `rst_n` low at cycle 6 → all outputs 0 asynchronously, no `done`; a restart with A=9, B=6 gives `done` with A=3.
- `start` held high throughout a 48/18 run → second operation accepted only in the IDLE cycle after DONE (cycle 13); no earlier restart.
- A=65535, B=1 with default `MAX_ITER` → N=65534; `done` at cycle 131072; A=1; `err` stays 0.
